// File: rtl/ex_serial_shift_pkg.sv
// Shared constants and types for the RV32I execute stage.
// Opcodes, funct3 codes, NOP encoding and shifter FSM encodings.
package ex_serial_shift_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        SH_IDLE  = 2'd0,
        SH_SHIFT = 2'd1,
        SH_DONE  = 2'd2
    } sh_state_e;

    typedef enum logic [1:0] {
        SK_SLL = 2'd0,
        SK_SRL = 2'd1,
        SK_SRA = 2'd2
    } sh_kind_e;

endpackage

// File: rtl/ex_serial_shift_if.sv
// ID/EX operand bundle in, write-back / redirect / stall bundle out.
// master drives operands, slave is the execute stage.
interface ex_serial_shift_if;

    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] op1_i;
    logic [31:0] op2_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wen_i;

    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        reg_wen_o;
    logic [31:0] jump_addr_o;
    logic        jump_en_o;
    logic        hold_flag_o;

    modport master (
        output inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
        input  rd_addr_o, rd_data_o, reg_wen_o, jump_addr_o, jump_en_o,
               hold_flag_o
    );

    modport slave (
        input  inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
        output rd_addr_o, rd_data_o, reg_wen_o, jump_addr_o, jump_en_o,
               hold_flag_o
    );

endinterface

// File: rtl/ex_serial_shift_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle.
// IDLE -> SHIFT (count down) -> DONE -> IDLE.
module ex_shifter
    import ex_serial_shift_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  sh_kind_e    kind,
    input  logic [31:0] data,
    input  logic [4:0]  shamt,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    sh_state_e   state;
    sh_kind_e    kind_q;
    logic [4:0]  count;
    logic [31:0] shadow;
    logic [4:0]  step;

    assign step   = (count < STEP) ? count : STEP;
    assign result = shadow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= SH_IDLE;
            kind_q <= SK_SLL;
            count  <= '0;
            shadow <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            unique case (state)
                SH_IDLE: begin
                    if (start) begin
                        shadow <= data;
                        kind_q <= kind;
                        count  <= shamt;
                        busy   <= 1'b1;
                        state  <= SH_SHIFT;
                    end
                end
                SH_SHIFT: begin
                    // arithmetic shift keeps the sign bit latched at start
                    unique case (kind_q)
                        SK_SLL:  shadow <= shadow << step;
                        SK_SRL:  shadow <= shadow >> step;
                        default: shadow <= 32'($signed(shadow) >>> step);
                    endcase
                    count <= count - step;
                    if (count == step) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= SH_DONE;
                    end
                end
                SH_DONE: begin
                    done  <= 1'b0;
                    state <= SH_IDLE;
                end
                default: state <= SH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_serial_shift.sv
// RV32I execute stage: single-cycle ALU, branch/jump resolution,
// and an iterative shifter that stalls the front end while busy.
module ex_serial_shift
    import ex_serial_shift_pkg::*;
#(
    parameter int SHIFT_STEP = 1
) (
    input logic              clk,
    input logic              rst,
    ex_serial_shift_if.slave ex
);

    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic [4:0]  shamt;

    logic [31:0] res;
    logic        res_vld;
    logic        jmp;
    logic [31:0] jaddr;
    logic        is_shift;
    sh_kind_e    kind;
    logic        start;
    logic        sh_busy;
    logic        sh_done;
    logic [31:0] sh_result;
    logic        wr_ok;

    assign opcode = ex.inst_i[6:0];
    assign f3     = ex.inst_i[14:12];
    assign alt    = ex.inst_i[30];
    assign op1    = ex.op1_i;
    assign op2    = ex.op2_i;
    assign pc     = ex.inst_addr_i;
    assign shamt  = op2[4:0];

    assign imm_b = {{20{ex.inst_i[31]}}, ex.inst_i[7],
                    ex.inst_i[30:25], ex.inst_i[11:8], 1'b0};
    assign imm_j = {{12{ex.inst_i[31]}}, ex.inst_i[19:12],
                    ex.inst_i[20], ex.inst_i[30:21], 1'b0};
    assign imm_u = {ex.inst_i[31:12], 12'b0};

    assign wr_ok = ex.reg_wen_i && (ex.rd_addr_i != 5'd0);

    always_comb begin
        res      = '0;
        res_vld  = 1'b0;
        jmp      = 1'b0;
        jaddr    = '0;
        is_shift = 1'b0;
        kind     = SK_SLL;
        case (opcode)
            OP_R, OP_I: begin
                res_vld = 1'b1;
                case (f3)
                    F3_ADD:  res = (opcode == OP_R && alt) ? op1 - op2
                                                          : op1 + op2;
                    F3_SLL:  begin is_shift = 1'b1; kind = SK_SLL; end
                    F3_SLT:  res = {31'b0, $signed(op1) < $signed(op2)};
                    F3_SLTU: res = {31'b0, op1 < op2};
                    F3_XOR:  res = op1 ^ op2;
                    F3_SR:   begin
                        is_shift = 1'b1;
                        kind     = alt ? SK_SRA : SK_SRL;
                    end
                    F3_OR:   res = op1 | op2;
                    default: res = op1 & op2;
                endcase
            end
            OP_LUI: begin
                res     = op2;
                res_vld = 1'b1;
            end
            OP_AUIPC: begin
                res     = pc + imm_u;
                res_vld = 1'b1;
            end
            OP_JAL: begin
                res     = pc + 32'd4;
                res_vld = 1'b1;
                jmp     = 1'b1;
                jaddr   = pc + imm_j;
            end
            OP_JALR: begin
                res     = pc + 32'd4;
                res_vld = 1'b1;
                jmp     = 1'b1;
                jaddr   = (op1 + op2) & 32'hFFFF_FFFE;
            end
            OP_B: begin
                jaddr = pc + imm_b;
                case (f3)
                    F3_BEQ:  jmp = (op1 == op2);
                    F3_BNE:  jmp = (op1 != op2);
                    F3_BLT:  jmp = ($signed(op1) < $signed(op2));
                    F3_BGE:  jmp = ($signed(op1) >= $signed(op2));
                    F3_BLTU: jmp = (op1 < op2);
                    F3_BGEU: jmp = (op1 >= op2);
                    default: jmp = 1'b0;
                endcase
            end
            default: ;
        endcase
        // zero-amount shifts bypass the iterative unit
        if (is_shift) begin
            res     = op1;
            res_vld = (shamt == 5'd0);
        end
    end

    assign start = is_shift && (shamt != 5'd0) && !sh_busy && !sh_done;

    ex_shifter #(
        .SHIFT_STEP(SHIFT_STEP)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kind   (kind),
        .data   (op1),
        .shamt  (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .result (sh_result)
    );

    assign ex.rd_addr_o = ex.rd_addr_i;

    always_comb begin
        ex.rd_data_o   = '0;
        ex.reg_wen_o   = 1'b0;
        ex.jump_addr_o = '0;
        ex.jump_en_o   = 1'b0;
        ex.hold_flag_o = 1'b0;
        if (!rst) begin
            ex.hold_flag_o = 1'b0;
        end else if (sh_done) begin
            ex.rd_data_o = sh_result;
            ex.reg_wen_o = wr_ok;
        end else if (sh_busy || start) begin
            ex.hold_flag_o = 1'b1;
        end else begin
            ex.rd_data_o   = res;
            ex.reg_wen_o   = wr_ok && res_vld;
            ex.jump_en_o   = jmp;
            ex.jump_addr_o = jaddr;
        end
    end

endmodule

// File: doc/ex_serial_shift.md
Name: ex_serial_shift

Overview:
Execute stage of the RV32I pipeline. It sits directly downstream of the ID/EX pipeline register and consumes that register's outputs. It performs ALU operations, resolves branches and jumps, and produces the write-back triple for the register file. Shifts run on an area-saving iterative shifter, which stalls the front end through hold_flag_o while busy.

Parameters:
SHIFT_STEP, 1, maximum bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
inst_i  in  32  instruction from ID/EX; INST_NOP when flushed
inst_addr_i  in  32  PC of inst_i
op1_i  in  32  rs1 value
op2_i  in  32  rs2 value or decoded I/U immediate
rd_addr_i  in  5  destination register
reg_wen_i  in  1  destination write enable from ID
rd_addr_o  out  5  write-back address
rd_data_o  out  32  write-back data
reg_wen_o  out  1  write-back enable
jump_addr_o  out  32  redirect target
jump_en_o  out  1  redirect request; upstream flushes IF/ID and ID/EX
hold_flag_o  out  1  stall request; PC, IF/ID and ID/EX freeze while high

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Clock is clk, reset is rst.
- rst low at a clock edge:
  - state goes to IDLE; shift counter and shadow registers clear.
  - While rst is low: reg_wen_o=0, jump_en_o=0, hold_flag_o=0, rd_data_o=0, jump_addr_o=0.
- Non-shift ops are combinational with zero added latency:
  - ADD, SUB, SLT, SLTU, XOR, OR, AND, including I forms.
  - LUI: result is op2_i.
  - AUIPC: result is inst_addr_i plus the U-immediate decoded from inst_i.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU):
  - Compare op1_i with op2_i.
  - If taken: jump_en_o=1 and jump_addr_o = inst_addr_i + sign-extended B-immediate from inst_i.
  - reg_wen_o=0.
- JAL: target = inst_addr_i + J-immediate.
- JALR: target = (op1_i + op2_i) with bit 0 cleared.
- JAL and JALR both write rd = inst_addr_i + 4, and both assert jump_en_o.
- reg_wen_o = reg_wen_i AND (rd_addr_i != 0) AND a result is valid this cycle.
- rd_addr_o mirrors rd_addr_i.
- Unknown opcodes behave as NOP: no write, no jump.
- Shift amount: op2_i[4:0] for both R and I forms.
- Shifts (SLL, SRL, SRA and I forms) use an FSM with states IDLE, SHIFT, DONE:
  - **IDLE, shift with shamt=0:** result is op1_i in the same cycle; no hold.
  - **IDLE, shift with shamt≠0:** hold_flag_o=1 combinationally and reg_wen_o=0. Latch op1, shift kind and count=shamt. Go to SHIFT.
  - **SHIFT:** hold_flag_o=1 and reg_wen_o=0. Shift the shadow register by min(SHIFT_STEP, count); count decrements by the same amount. When the remaining count reaches 0, go to DONE.
  - **DONE:** hold_flag_o=0, reg_wen_o as above, rd_data_o = shadow result. The instruction in inst_i is not re-detected as a new shift. Go to IDLE.
- Shift timing:
  - Occupancy is ceil(shamt/SHIFT_STEP)+2 cycles.
  - hold_flag_o is high for all cycles except DONE.
- SRA fills vacated bits with the sign bit captured at latch time.
- jump_en_o and a busy shift cannot coincide: the stage holds a single instruction, and ID/EX is frozen.
- Reset mid-shift: abort, no write, IDLE on the next cycle.

Decomposition:
- Shared defines file (defines.v) holds:
  - opcode constants: OP_R, OP_I, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - funct3/funct7 constants.
  - INST_NOP.
  - FSM state encodings.
- Sub-module ex_shifter holds the FSM, counter and shadow register. It exposes:
  - inputs: start, kind, data, shamt
  - outputs: busy, done, result

Test Plan:
- ADD with op1=0x00000005, op2=0xFFFFFFFF, rd=3 -> same cycle: rd_data_o=0x00000004, reg_wen_o=1, hold_flag_o=0.
- SLLI with SHIFT_STEP=1, op1=0x00000001, shamt=3 -> hold_flag_o high for cycles 0-3; cycle 4 (DONE): rd_data_o=0x00000008, reg_wen_o=1.
- SRA with SHIFT_STEP=4, op1=0x80000000, shamt=31 -> 8 SHIFT cycles, hold for 9 cycles; DONE: rd_data_o=0xFFFFFFFF.
- BEQ with op1=op2=7, inst_addr=0x100, imm=-8 -> jump_en_o=1, jump_addr_o=0x0F8, reg_wen_o=0. BNE with the same operands -> jump_en_o=0.
- JALR with op1=0x2001, op2=0x2, inst_addr=0x40 -> jump_addr_o=0x2002, rd_data_o=0x44, jump_en_o=1.
- SLL with shamt=20 and rst driven low on the 3rd SHIFT cycle -> no reg_wen_o pulse, hold_flag_o=0 while reset is low, state IDLE; the next ADD completes normally.
